// File: rtl/guess_engine.sv
// Number-guessing engine: captures a pseudo-random secret from a free-running
// counter on new_game and scores up to MAX_TRIES guesses against it.
module guess_engine #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned MAX_TRIES = 7,
    localparam int unsigned TW       = $clog2(MAX_TRIES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             new_game,
    input  logic             submit,
    input  logic [WIDTH-1:0] guess,
    output logic             is_lt,
    output logic             is_eq,
    output logic             is_gt,
    output logic [TW-1:0]    tries_left,
    output logic             playing,
    output logic             won,
    output logic             lost,
    output logic [WIDTH-1:0] reveal
);

    typedef enum logic [1:0] {StIdle, StPlay, StWin, StLose} state_e;

    localparam logic [TW-1:0] MaxTries = TW'(MAX_TRIES);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] secret_q, secret_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic             submit_q;
    logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
    logic             accept;

    assign cnt_d  = cnt_q + WIDTH'(1);
    assign accept = submit & ~submit_q & (state_q == StPlay);

    always_comb begin
        state_d  = state_q;
        secret_d = secret_q;
        tries_d  = tries_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        if (new_game) begin
            // Restart wins over any same-cycle guess; secret is the pre-increment count.
            state_d  = StPlay;
            secret_d = cnt_q;
            tries_d  = MaxTries;
            lt_d     = 1'b0;
            eq_d     = 1'b0;
            gt_d     = 1'b0;
        end else if (accept) begin
            lt_d = (guess < secret_q);
            eq_d = (guess == secret_q);
            gt_d = (guess > secret_q);
            if (tries_q != '0) begin
                tries_d = tries_q - TW'(1);
            end
            if (guess == secret_q) begin
                state_d = StWin;
            end else if (tries_q <= TW'(1)) begin
                state_d = StLose;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            secret_q <= '0;
            tries_q  <= '0;
            submit_q <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            secret_q <= secret_d;
            tries_q  <= tries_d;
            submit_q <= submit;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
        end
    end

    assign is_lt      = lt_q;
    assign is_eq      = eq_q;
    assign is_gt      = gt_q;
    assign tries_left = tries_q;
    assign playing    = (state_q == StPlay);
    assign won        = (state_q == StWin);
    assign lost       = (state_q == StLose);
    assign reveal     = (won | lost) ? secret_q : '0;

endmodule

// File: tb/tb_guess_engine.sv
// Directed bench for guess_engine: one 7-try and one 3-try instance sharing clock and reset.
module tb_guess_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       ng7 = 1'b0, sb7 = 1'b0, ng3 = 1'b0, sb3 = 1'b0;
    logic [2:0] g7 = '0, g3 = '0;
    logic       lt7, eq7, gt7, pl7, wn7, ls7;
    logic       lt3, eq3, gt3, pl3, wn3, ls3;
    logic [2:0] tl7, rv7, rv3;
    logic [1:0] tl3;
    logic [11:0] obs7;
    logic [10:0] obs3;

    int vecs = 0;
    int errs = 0;

    // {lt,eq,gt, tries, playing,won,lost, reveal}
    assign obs7 = {lt7, eq7, gt7, tl7, pl7, wn7, ls7, rv7};
    assign obs3 = {lt3, eq3, gt3, tl3, pl3, wn3, ls3, rv3};

    guess_engine #(.WIDTH(3), .MAX_TRIES(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .new_game(ng7), .submit(sb7), .guess(g7),
        .is_lt(lt7), .is_eq(eq7), .is_gt(gt7), .tries_left(tl7),
        .playing(pl7), .won(wn7), .lost(ls7), .reveal(rv7)
    );

    guess_engine #(.WIDTH(3), .MAX_TRIES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .new_game(ng3), .submit(sb3), .guess(g3),
        .is_lt(lt3), .is_eq(eq3), .is_gt(gt3), .tries_left(tl3),
        .playing(pl3), .won(wn3), .lost(ls3), .reveal(rv3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, then pulse new_game on the k-th edge after release (secret = k-1 mod 8).
    task automatic start_at(input int k);
        rst_n = 1'b0; ng7 = 1'b0; ng3 = 1'b0; sb7 = 1'b0; sb3 = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (k - 1) tick();
        ng7 = 1'b1; ng3 = 1'b1;
        tick();
        ng7 = 1'b0; ng3 = 1'b0;
    endtask

    task automatic sub7(input logic [2:0] v);
        g7 = v; sb7 = 1'b1;
        tick();
        sb7 = 1'b0;
        tick();
    endtask

    task automatic sub3(input logic [2:0] v);
        g3 = v; sb3 = 1'b1;
        tick();
        sb3 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        vecs++;
        if (obs7 !== 12'h000) begin
            $display("FAIL reset7: got %h want %h", obs7, 12'h000); errs++;
        end
        vecs++;
        if (obs3 !== 11'h000) begin
            $display("FAIL reset3: got %h want %h", obs3, 11'h000); errs++;
        end
    endtask

    task automatic test_secret_win();
        start_at(5);
        vecs++;
        if (obs7 !== {3'b000, 3'd7, 3'b100, 3'd0}) begin
            $display("FAIL start7: got %h want %h", obs7, {3'b000, 3'd7, 3'b100, 3'd0}); errs++;
        end
        sub7(3'd2);
        vecs++;
        if (obs7 !== {3'b100, 3'd6, 3'b100, 3'd0}) begin
            $display("FAIL guess2: got %h want %h", obs7, {3'b100, 3'd6, 3'b100, 3'd0}); errs++;
        end
        sub7(3'd6);
        vecs++;
        if (obs7 !== {3'b001, 3'd5, 3'b100, 3'd0}) begin
            $display("FAIL guess6: got %h want %h", obs7, {3'b001, 3'd5, 3'b100, 3'd0}); errs++;
        end
        sub7(3'd4);
        vecs++;
        if (obs7 !== {3'b010, 3'd4, 3'b010, 3'd4}) begin
            $display("FAIL guess4_win: got %h want %h", obs7, {3'b010, 3'd4, 3'b010, 3'd4}); errs++;
        end
        sub7(3'd1);
        vecs++;
        if (obs7 !== {3'b010, 3'd4, 3'b010, 3'd4}) begin
            $display("FAIL win_hold: got %h want %h", obs7, {3'b010, 3'd4, 3'b010, 3'd4}); errs++;
        end
    endtask

    task automatic test_lose();
        start_at(5);
        vecs++;
        if (obs3 !== {3'b000, 2'd3, 3'b100, 3'd0}) begin
            $display("FAIL start3: got %h want %h", obs3, {3'b000, 2'd3, 3'b100, 3'd0}); errs++;
        end
        sub3(3'd0);
        vecs++;
        if (obs3 !== {3'b100, 2'd2, 3'b100, 3'd0}) begin
            $display("FAIL lose_g0: got %h want %h", obs3, {3'b100, 2'd2, 3'b100, 3'd0}); errs++;
        end
        sub3(3'd1);
        vecs++;
        if (obs3 !== {3'b100, 2'd1, 3'b100, 3'd0}) begin
            $display("FAIL lose_g1: got %h want %h", obs3, {3'b100, 2'd1, 3'b100, 3'd0}); errs++;
        end
        sub3(3'd2);
        vecs++;
        if (obs3 !== {3'b100, 2'd0, 3'b001, 3'd4}) begin
            $display("FAIL lose_g2: got %h want %h", obs3, {3'b100, 2'd0, 3'b001, 3'd4}); errs++;
        end
        sub3(3'd4);
        vecs++;
        if (obs3 !== {3'b100, 2'd0, 3'b001, 3'd4}) begin
            $display("FAIL lose_hold: got %h want %h", obs3, {3'b100, 2'd0, 3'b001, 3'd4}); errs++;
        end
    endtask

    task automatic test_win_last();
        start_at(5);
        sub3(3'd0);
        sub3(3'd1);
        vecs++;
        if (obs3 !== {3'b100, 2'd1, 3'b100, 3'd0}) begin
            $display("FAIL last_pre: got %h want %h", obs3, {3'b100, 2'd1, 3'b100, 3'd0}); errs++;
        end
        sub3(3'd4);
        vecs++;
        if (obs3 !== {3'b010, 2'd0, 3'b010, 3'd4}) begin
            $display("FAIL last_win: got %h want %h", obs3, {3'b010, 2'd0, 3'b010, 3'd4}); errs++;
        end
    endtask

    task automatic test_edge_detect();
        start_at(5);
        g7 = 3'd0; sb7 = 1'b1;
        repeat (10) tick();
        sb7 = 1'b0;
        tick();
        vecs++;
        if (obs7 !== {3'b100, 3'd6, 3'b100, 3'd0}) begin
            $display("FAIL held_submit: got %h want %h", obs7, {3'b100, 3'd6, 3'b100, 3'd0}); errs++;
        end
    endtask

    task automatic test_priority();
        start_at(5);
        sub7(3'd0);
        // Edge 8 after release: counter holds 7 before it.
        ng7 = 1'b1; sb7 = 1'b1; g7 = 3'd0;
        tick();
        ng7 = 1'b0; sb7 = 1'b0;
        vecs++;
        if (obs7 !== {3'b000, 3'd7, 3'b100, 3'd0}) begin
            $display("FAIL restart_prio: got %h want %h", obs7, {3'b000, 3'd7, 3'b100, 3'd0}); errs++;
        end
        tick();
        sub7(3'd7);
        vecs++;
        if (obs7 !== {3'b010, 3'd6, 3'b010, 3'd7}) begin
            $display("FAIL new_secret: got %h want %h", obs7, {3'b010, 3'd6, 3'b010, 3'd7}); errs++;
        end
        ng7 = 1'b1;
        tick();
        ng7 = 1'b0;
        vecs++;
        if (obs7 !== {3'b000, 3'd7, 3'b100, 3'd0}) begin
            $display("FAIL win_restart: got %h want %h", obs7, {3'b000, 3'd7, 3'b100, 3'd0}); errs++;
        end
    endtask

    task automatic test_wrap();
        start_at(9);
        sub7(3'd1);
        vecs++;
        if (obs7 !== {3'b001, 3'd6, 3'b100, 3'd0}) begin
            $display("FAIL wrap_g1: got %h want %h", obs7, {3'b001, 3'd6, 3'b100, 3'd0}); errs++;
        end
        sub7(3'd0);
        vecs++;
        if (obs7 !== {3'b010, 3'd5, 3'b010, 3'd0}) begin
            $display("FAIL wrap_g0: got %h want %h", obs7, {3'b010, 3'd5, 3'b010, 3'd0}); errs++;
        end
    endtask

    task automatic test_reset_midgame();
        start_at(5);
        sub7(3'd2);
        vecs++;
        if (obs7 !== {3'b100, 3'd6, 3'b100, 3'd0}) begin
            $display("FAIL mid_pre: got %h want %h", obs7, {3'b100, 3'd6, 3'b100, 3'd0}); errs++;
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if (obs7 !== 12'h000) begin
            $display("FAIL async_rst7: got %h want %h", obs7, 12'h000); errs++;
        end
        vecs++;
        if (obs3 !== 11'h000) begin
            $display("FAIL async_rst3: got %h want %h", obs3, 11'h000); errs++;
        end
        #2;
        rst_n = 1'b1;
        sub7(3'd4);
        sub7(3'd4);
        vecs++;
        if (obs7 !== 12'h000) begin
            $display("FAIL idle_submit: got %h want %h", obs7, 12'h000); errs++;
        end
    endtask

    initial begin
        test_reset();
        test_secret_win();
        test_lose();
        test_win_last();
        test_edge_detect();
        test_priority();
        test_wrap();
        test_reset_midgame();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/guess_engine.md
# guess_engine

Parametrised, clocked number-guessing engine: on each new game it captures a pseudo-random secret and scores up to MAX_TRIES guesses. Each guess is scored as below, equal or above the secret. Sits between debounced/synchronised board inputs (switches as guess, keys as submit/new-game) and the LED/HEX display logic. Generalises the fixed 3-bit combinational guess checker to any width, adding attempt counting, game state, win/lose detection and secret reveal.

## Interface
- WIDTH, 3: guess/secret width in bits, ≥1
- MAX_TRIES, 7: guesses allowed per game, ≥1
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- new_game  input  1  level-sensitive; sampled every cycle; starts/restarts a game
- submit  input  1  level; rising edge (internally detected) submits one guess
- guess  input  WIDTH  unsigned guess value, sampled on the accepting edge
- is_lt  output  1  last guess < secret (registered, held)
- is_eq  output  1  last guess == secret (registered, held)
- is_gt  output  1  last guess > secret (registered, held)
- tries_left  output  $clog2(MAX_TRIES+1)  remaining guesses
- playing  output  1  state == PLAY
- won  output  1  state == WIN
- lost  output  1  state == LOSE
- reveal  output  WIDTH  secret while won or lost, else 0

## Operation
- Seed counter: WIDTH-bit free-running up-counter, +1 every cycle, wraps 2^WIDTH−1 → 0; never stops.
- Submit edge: submit_d register; accept = submit & ~submit_d & (state==PLAY). Holding submit high counts once.
- States: IDLE (reset), PLAY, WIN, LOSE.
- new_game=1 in any state (highest priority): secret ← current counter value (pre-increment); tries_left ← MAX_TRIES; is_lt/eq/gt ← 0; → PLAY. Any submit edge in the same cycle is discarded; submit_d still updates.
- PLAY, accept: compare guess vs secret unsigned; exactly one of is_lt/is_eq/is_gt ← 1; tries_left ← tries_left−1.
  - eq → WIN (eq takes precedence, even on the final try).
  - not eq and tries_left==1 → LOSE (tries_left becomes 0).
  - otherwise stay PLAY.
- IDLE/WIN/LOSE: submit ignored; flags, tries_left and secret held until new_game.
- new_game held high: re-captures secret and re-arms every cycle; game proceeds once deasserted.
- Outputs playing/won/lost/reveal decoded combinationally from registered state and secret; exactly one of playing/won/lost high outside IDLE, none in IDLE.

## Timing
- Reset (asynchronous assert, any time including mid-game): state IDLE; counter, secret, submit_d = 0; is_lt/is_eq/is_gt = 0; tries_left = 0; playing/won/lost = 0; reveal = 0.
- Counter is 0 during reset; first rising edge after rst_n deasserts makes it 1.
- Latency: input sampled at edge k → all outputs reflect it after edge k (1 cycle).
- Consecutive guesses need submit low for ≥1 sampled cycle between rising edges; max rate one guess per 2 cycles.
- tries_left never underflows; never exceeds MAX_TRIES.

## Test plan
- Reset values: WIDTH=3, MAX_TRIES=7; assert rst_n=0 mid-PLAY → all outputs 0 immediately (before next clk edge); IDLE; submit pulses afterwards cause no change.
- Secret capture and win: release reset, new_game=1 only at 5th edge → secret=4, tries_left=7, playing=1; submit guess=2 → is_lt=1, tries_left=6; guess=6 → is_gt=1, tries_left=5; guess=4 → is_eq=1, won=1, reveal=4, tries_left=4.
- Lose: MAX_TRIES=3, secret=4; guesses 0,1,2 → is_lt each, tries_left 2,1,0, lost=1, reveal=4; a fourth submit edge changes nothing.
- Win on last try: MAX_TRIES=3, secret=4; guesses 0,1,4 → won=1, lost=0, tries_left=0.
- Edge detection: submit held high 10 cycles with guess=0 → tries_left drops by exactly 1.
- Priority and restart: during PLAY, assert new_game and a submit edge on the same edge → tries_left=MAX_TRIES, flags 0, new secret = counter value at that edge; in WIN, new_game → PLAY with flags cleared, reveal=0. Counter wrap: WIDTH=3, new_game at 9th edge after reset → secret=0.
